// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RISC-V M-extension multiply/divide unit:
// funct3 opcodes, FSM state encoding and opcode-decoding helpers.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic returns_high(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Iterative multiply/divide unit: one bit per cycle over a shared 2*XLEN shift
// register, with a single-cycle path for divide-by-zero and signed overflow.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_out
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t              state, state_next;
  logic [2:0]          op_q;
  logic                neg_q, neg_r;
  logic [2*XLEN-1:0]   acc, acc_next;
  logic [XLEN-1:0]     b_mag;
  logic [CW-1:0]       cnt;

  logic                sign_a, sign_b, div_zero, overflow, fast, accept;
  logic [XLEN-1:0]     a_mag_in, b_mag_in, fast_res;
  logic [XLEN:0]       rem_sh, diff, sum;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     q_raw, r_raw, quo, rem, result;

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign accept  = (state == IDLE) && i_valid && !i_flush;

  // Request decode: operand magnitudes and the fast-path cases
  always_comb begin
    sign_a   = a_signed(i_op) && i_A[XLEN-1];
    sign_b   = b_signed(i_op) && i_B[XLEN-1];
    a_mag_in = sign_a ? -i_A : i_A;
    b_mag_in = sign_b ? -i_B : i_B;
    div_zero = is_div(i_op) && (i_B == '0);
    overflow = is_div(i_op) && a_signed(i_op) &&
               (i_A == {1'b1, {(XLEN-1){1'b0}}}) && (&i_B);
    fast     = div_zero || overflow;
    fast_res = '0;
    if (div_zero)      fast_res = i_op[1] ? i_A : '1;
    else if (overflow) fast_res = i_op[1] ? '0 : i_A;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_mag};
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    acc_next = acc;
    if (is_div(op_q)) begin
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction applied to the value produced by the final iteration
  always_comb begin
    prod  = neg_q ? -acc_next : acc_next;
    q_raw = acc_next[XLEN-1:0];
    r_raw = acc_next[2*XLEN-1:XLEN];
    quo   = neg_q ? -q_raw : q_raw;
    rem   = neg_r ? -r_raw : r_raw;
    if (is_div(op_q))            result = op_q[1] ? rem : quo;
    else if (returns_high(op_q)) result = prod[2*XLEN-1:XLEN];
    else                         result = prod[XLEN-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid) state_next = fast ? DONE : BUSY;
      BUSY:    if (cnt == LAST) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
      b_mag <= '0;
      cnt   <= '0;
      o_out <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
      acc   <= {{XLEN{1'b0}}, a_mag_in};
      b_mag <= b_mag_in;
      cnt   <= '0;
      if (fast) o_out <= fast_res;
    end else if (state == BUSY && !i_flush) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) o_out <= result;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu at XLEN=32: one task per scenario,
// each with hand-computed expected results and latencies.
module tb_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            flush;
  logic            out_valid;
  logic            res_ready;
  logic [XLEN-1:0] out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_op    (op),
    .i_A     (a),
    .i_B     (b),
    .i_flush (flush),
    .o_valid (out_valid),
    .i_ready (res_ready),
    .o_out   (out)
  );

  // Present a request for one edge, then wait (bounded) for o_valid.
  // lat is the cycle number in which o_valid was first seen (accept cycle = 0).
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       output logic [XLEN-1:0] res, output int lat);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'd0; a = 32'hDEADBEEF; b = 32'h12345678;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out;
  endtask

  task automatic complete();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (out_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", out_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out !== 32'h0) begin bad++; $display("[TB] FAIL reset_out got=%h want=00000000", out); end
  endtask

  task automatic test_mul();
    logic [XLEN-1:0] r; int lat;
    issue(3'd0, 32'd7, 32'hFFFFFFFD, r, lat);
    total++; if (r !== 32'hFFFFFFEB) begin bad++; $display("[TB] FAIL mul got=%h want=ffffffeb", r); end
    total++; if (lat !== 33) begin bad++; $display("[TB] FAIL mul_latency got=%0d want=33", lat); end
    complete();
    total++; if (out_ready !== 1'b1) begin bad++; $display("[TB] FAIL mul_ready_after got=%b want=1", out_ready); end
    issue(3'd1, 32'h80000000, 32'h80000000, r, lat);
    total++; if (r !== 32'h40000000) begin bad++; $display("[TB] FAIL mulh got=%h want=40000000", r); end
    total++; if (lat !== 33) begin bad++; $display("[TB] FAIL mulh_latency got=%0d want=33", lat); end
    complete();
  endtask

  task automatic test_mulh_variants();
    logic [XLEN-1:0] r; int lat;
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL mulhsu got=%h want=ffffffff", r); end
    complete();
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL mulhu got=%h want=fffffffe", r); end
    complete();
  endtask

  task automatic test_div();
    logic [XLEN-1:0] r; int lat;
    issue(3'd4, 32'hFFFFFFF9, 32'd2, r, lat);
    total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL div_neg got=%h want=fffffffd", r); end
    total++; if (lat !== 33) begin bad++; $display("[TB] FAIL div_latency got=%0d want=33", lat); end
    complete();
    issue(3'd6, 32'hFFFFFFF9, 32'd2, r, lat);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL rem_neg got=%h want=ffffffff", r); end
    complete();
    issue(3'd5, 32'd100, 32'd7, r, lat);
    total++; if (r !== 32'd14) begin bad++; $display("[TB] FAIL divu got=%h want=0000000e", r); end
    complete();
    issue(3'd7, 32'd100, 32'd7, r, lat);
    total++; if (r !== 32'd2) begin bad++; $display("[TB] FAIL remu got=%h want=00000002", r); end
    complete();
  endtask

  task automatic test_fast_path();
    logic [XLEN-1:0] r; int lat;
    issue(3'd4, 32'd5, 32'd0, r, lat);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL div_by_zero got=%h want=ffffffff", r); end
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL div_by_zero_latency got=%0d want=1", lat); end
    complete();
    issue(3'd6, 32'd5, 32'd0, r, lat);
    total++; if (r !== 32'd5) begin bad++; $display("[TB] FAIL rem_by_zero got=%h want=00000005", r); end
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL rem_by_zero_latency got=%0d want=1", lat); end
    complete();
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, r, lat);
    total++; if (r !== 32'h80000000) begin bad++; $display("[TB] FAIL div_overflow got=%h want=80000000", r); end
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL div_overflow_latency got=%0d want=1", lat); end
    complete();
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, r, lat);
    total++; if (r !== 32'h0) begin bad++; $display("[TB] FAIL rem_overflow got=%h want=00000000", r); end
    complete();
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] r; int lat;
    issue(3'd5, 32'd100, 32'd7, r, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out !== 32'd14) begin bad++; $display("[TB] FAIL stall_out[%0d] got=%h want=0000000e", i, out); end
      total++; if (out_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready[%0d] got=%b want=0", i, out_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d] got=%b want=1", i, out_valid); end
    end
    complete();
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] r; int lat;
    in_valid = 1'b1; op = 3'd0; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (out_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready got=%b want=1", out_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b want=0", out_valid); end
    repeat (30) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_valid got=%b want=0", out_valid); end
    end
    issue(3'd5, 32'd9, 32'd3, r, lat);
    total++; if (r !== 32'd3) begin bad++; $display("[TB] FAIL divu_after_flush got=%h want=00000003", r); end
    total++; if (lat !== 33) begin bad++; $display("[TB] FAIL divu_after_flush_latency got=%0d want=33", lat); end
    complete();
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] r; int lat;
    in_valid = 1'b1; op = 3'd0; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got=%b want=0", out_valid); end
    total++; if (out !== 32'h0) begin bad++; $display("[TB] FAIL midreset_out got=%h want=00000000", out); end
    total++; if (out_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_ready got=%b want=1", out_ready); end
    issue(3'd0, 32'd3, 32'd4, r, lat);
    total++; if (r !== 32'd12) begin bad++; $display("[TB] FAIL mul_after_reset got=%h want=0000000c", r); end
    complete();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] r; int lat; int cyc;
    res_ready = 1'b1;
    in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cyc !== XLEN + 2) begin bad++; $display("[TB] FAIL b2b_period got=%0d want=%0d", cyc, XLEN + 2); end
    total++; if (out !== 32'd15) begin bad++; $display("[TB] FAIL b2b_first got=%h want=0000000f", out); end
    issue(3'd5, 32'd20, 32'd4, r, lat);
    total++; if (r !== 32'd5) begin bad++; $display("[TB] FAIL b2b_second got=%h want=00000005", r); end
    complete();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
    flush = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_mulh_variants();
    test_div();
    test_fast_path();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
